// File: rtl/fir_decimator.sv
// Keeps one in every N FIR output samples and buffers them in a show-ahead FIFO.
// Optional FIR_DECIMATOR_DROP_CNT_EN adds a saturating drop_count output.
module fir_decimator #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    decim_factor,
    input  logic                          single_valid_in,
    input  logic [15:0]                   data_in,
    output logic                          m_valid,
    output logic [15:0]                   m_data,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef FIR_DECIMATOR_DROP_CNT_EN
    output logic [15:0]                   drop_count,
`endif
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]    phase_q, phase_d;
    logic [7:0]    n_eff_q, n_eff_d;
    logic [7:0]    n_req;
    logic [AW:0]   wptr_q, rptr_q;
    logic [15:0]   mem [FIFO_DEPTH];
    logic          overflow_q;
    logic          keep, full, empty, push, pop, drop;

    assign n_req = (decim_factor == 8'd0) ? 8'd1 : decim_factor;
    assign keep  = single_valid_in && (phase_q == 8'd0);

    // The factor is only re-sampled at a wrap so a period never gets cut short.
    always_comb begin
        phase_d = phase_q;
        n_eff_d = n_eff_q;
        if (single_valid_in) begin
            if (phase_q == n_eff_q - 8'd1) begin
                phase_d = 8'd0;
                n_eff_d = n_req;
            end else begin
                phase_d = phase_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 8'd0;
            n_eff_q <= n_req;
        end else begin
            phase_q <= phase_d;
            n_eff_q <= n_eff_d;
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign pop   = m_valid && m_ready;
    assign push  = keep && (!full || pop);
    assign drop  = keep && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            overflow_q <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= data_in;
    end

    assign m_valid    = !empty;
    // Gate the head so unwritten storage never leaks X onto m_data.
    assign m_data     = m_valid ? mem[rptr_q[AW-1:0]] : 16'd0;
    assign fifo_count = wptr_q - rptr_q;
    assign overflow   = overflow_q;

`ifdef FIR_DECIMATOR_DROP_CNT_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_q <= 16'd0;
        end else if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: decimation, FIFO full/drop, factor change, reset.
module tb_fir_decimator;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  decim_factor;
    logic        single_valid_in;
    logic [15:0] data_in;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef FIR_DECIMATOR_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fir_decimator #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .decim_factor    (decim_factor),
        .single_valid_in (single_valid_in),
        .data_in         (data_in),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_ready         (m_ready),
        .fifo_count      (fifo_count),
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        .drop_count      (drop_count),
`endif
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] factor);
        decim_factor    = factor;
        single_valid_in = 1'b0;
        rst             = 1'b1;
        tick();
        rst             = 1'b0;
    endtask

    task automatic strobe(input int value);
        single_valid_in = 1'b1;
        data_in         = 16'(value);
        tick();
        single_valid_in = 1'b0;
    endtask

    int pass_vals [3]   = '{100, -200, 300};
    int dec3_exp [3]    = '{1, 4, 7};
    int chg_exp [4]     = '{1, 5, 7, 9};
    int fullpop_exp [4] = '{22, 23, 24, 30};
    int ovf_seen;

    initial begin
        m_ready = 1'b0;
        data_in = 16'd0;
        do_reset(8'd1);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_m_data", int'(m_data), 0);

        // Pass-all: each sample appears one cycle after its strobe and is popped at once.
        m_ready = 1'b1;
        foreach (pass_vals[i]) begin
            strobe(pass_vals[i]);
            check("pass_valid", int'(m_valid), 1);
            check("pass_data", int'($signed(m_data)), pass_vals[i]);
            check("pass_overflow", int'(overflow), 0);
            tick();
            check("pass_drained", int'(m_valid), 0);
            for (int c = 0; c < 30; c++) begin
                if (overflow) check("pass_overflow_idle", int'(overflow), 0);
                tick();
            end
        end

        // Decimate by 3, back-to-back strobes.
        m_ready = 1'b0;
        do_reset(8'd3);
        for (int v = 1; v <= 9; v++) strobe(v);
        check("dec3_count", int'(fifo_count), 3);
        m_ready = 1'b1;
        foreach (dec3_exp[i]) begin
            check("dec3_data", int'($signed(m_data)), dec3_exp[i]);
            tick();
        end
        check("dec3_empty", int'(m_valid), 0);

        // decim_factor = 0 passes everything.
        m_ready = 1'b0;
        do_reset(8'd0);
        for (int v = 10; v <= 12; v++) strobe(v);
        check("dec0_count", int'(fifo_count), 3);
        m_ready = 1'b1;
        for (int v = 10; v <= 12; v++) begin
            check("dec0_data", int'($signed(m_data)), v);
            tick();
        end

        // Full and drop: 6 strobes into a depth-4 FIFO.
        m_ready = 1'b0;
        do_reset(8'd1);
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin
            strobe(21 + i);
            check("full_ovf_pulse", int'(overflow), (i >= 4) ? 1 : 0);
            ovf_seen += int'(overflow);
        end
        tick();
        check("full_ovf_clear", int'(overflow), 0);
        check("full_ovf_total", ovf_seen, 2);
        check("full_count", int'(fifo_count), 4);
        check("full_head", int'($signed(m_data)), 21);
`ifdef FIR_DECIMATOR_DROP_CNT_EN
        check("full_drop_count", int'(drop_count), 2);
`endif

        // Full with concurrent pop: 21 leaves, 30 enters as the tail.
        m_ready = 1'b1;
        strobe(30);
        check("fullpop_overflow", int'(overflow), 0);
        check("fullpop_count", int'(fifo_count), 4);
        foreach (fullpop_exp[i]) begin
            check("fullpop_data", int'($signed(m_data)), fullpop_exp[i]);
            tick();
        end
        check("fullpop_empty", int'(m_valid), 0);

        // Factor change mid-period takes effect at the next kept sample.
        m_ready = 1'b0;
        do_reset(8'd4);
        strobe(1);
        strobe(2);
        decim_factor = 8'd2;
        for (int v = 3; v <= 9; v++) strobe(v);
        check("chg_count", int'(fifo_count), 4);
        m_ready = 1'b1;
        foreach (chg_exp[i]) begin
            check("chg_data", int'($signed(m_data)), chg_exp[i]);
            tick();
        end

        // Reset mid-stream with 3 entries queued and phase=1.
        m_ready = 1'b0;
        do_reset(8'd2);
        for (int v = 41; v <= 45; v++) strobe(v);
        check("mid_count_before", int'(fifo_count), 3);
        do_reset(8'd2);
        check("mid_valid", int'(m_valid), 0);
        check("mid_count", int'(fifo_count), 0);
        check("mid_overflow", int'(overflow), 0);
        strobe(50);
        check("mid_first_kept_valid", int'(m_valid), 1);
        check("mid_first_kept_data", int'($signed(m_data)), 50);
        check("mid_first_kept_count", int'(fifo_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the low-pass FIR: takes the filter's single-cycle output strobes and 16-bit signed samples, keeps one sample in every N (N is run-time programmable), and buffers kept samples in a small show-ahead FIFO. A consumer drains the FIFO over a valid/ready handshake. The FIR needs no back-pressure because overflow is handled here by dropping samples, which is flagged.

## Interface
- FIFO_DEPTH, 16: FIFO entries; power of two, 4..256.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- decim_factor  input  8  keep 1 of every N input samples; 0 and 1 both mean pass-all.
- single_valid_in  input  1  one-cycle strobe; data_in is valid this cycle (FIR valid_out).
- data_in  input  16  signed sample (FIR data_out).
- m_valid  output  1  FIFO head is valid.
- m_data  output  16  signed FIFO head sample.
- m_ready  input  1  consumer accepts head when m_valid && m_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  one-cycle pulse when a kept sample is dropped because the FIFO is full.

## Operation
- Phase counter `phase` (8-bit) counts accepted strobes. A strobe with phase==0 is kept, i.e. pushed into the FIFO. Every strobe advances phase; phase wraps to 0 after reaching N_eff-1.
- N_eff = max(decim_factor,1). It is latched into an internal register on reset exit and at every wrap to 0, so mid-period changes take effect at the next kept sample.
- After reset, the first strobe is always kept.
- Strobes with single_valid_in low are ignored. Back-to-back strobes on consecutive cycles must be handled at full rate.
- FIFO: circular buffer with read/write pointers one bit wider than the address. Full when the addresses match and the MSBs differ; empty when the pointers are equal.
- Push: kept sample and (not full, or pop in the same cycle). Pop: m_valid && m_ready.
- Simultaneous push and pop:
  - When full: both happen; count stays at FIFO_DEPTH and no overflow.
  - When empty: push only; pop is impossible because m_valid=0.
- Kept sample with FIFO full and no pop: sample discarded, overflow=1 for one cycle, FIFO unchanged.
- Show-ahead: m_data always reflects the head entry. m_data is don't-care while m_valid=0, but it is driven from registers or RAM and is never X after reset.
- Data path is pass-through: no scaling, no sign change.

## Timing
- Reset values: m_valid=0, fifo_count=0, overflow=0, m_data=0, phase=0, pointers=0, N_eff latched from decim_factor.
- Reset mid-operation discards all FIFO contents and the phase on the next edge. No pulse on overflow during or immediately after reset.
- Latency from a kept strobe at edge k into an empty FIFO: m_valid=1 and m_data=sample after edge k (visible in cycle k+1).
- fifo_count updates on the same edge as the push or pop.
- Pop at edge k: the next head is presented after edge k; m_valid drops in the same cycle if the FIFO became empty.
- overflow is asserted in the cycle after the dropping strobe's edge, for exactly one cycle.
- Throughput: one push and one pop per cycle.

## Configuration
- FIR_DECIMATOR_DROP_CNT_EN
  - Defined: adds output `drop_count` (16-bit). It increments on every overflow, saturates at 16'hFFFF, and is cleared by rst.
  - Undefined: the port and counter do not exist. The overflow pulse is unaffected in both cases.

## Test plan
- Pass-all: decim_factor=1, m_ready=1, strobes 100,-200,300 every 32 cycles -> m_data 100,-200,300 in order, each one cycle after its strobe; overflow never set.
- Decimate by 3: decim_factor=3, strobes 1..9 -> FIFO receives 1,4,7 only; decim_factor=0 behaves as pass-all.
- Full and drop: FIFO_DEPTH=4, m_ready=0, decim_factor=1, 6 strobes -> fifo_count=4, overflow pulses twice, head=first sample; with macro on, drop_count=2.
- Full with concurrent pop: FIFO full, strobe coincident with m_ready=1 -> no overflow, count stays 4, new sample becomes the tail.
- Factor change mid-period: decim_factor 4 -> 2 after the 2nd strobe -> kept samples are 1, 5, 7, 9.
- Reset mid-stream: 3 entries queued and phase=1, rst high for one cycle -> m_valid=0, count=0; the next strobe is kept.
